// File: rtl/defines_pkg.sv
// Shared types and sizing for the BDF program sequencer: opcode and state
// enums plus the default buffer count and program geometry.
package defines_pkg;

  localparam int NUM_BUFFERS = 12;
  localparam int CODE_LENGTH = 128;
  localparam int CODE_WIDTH  = 2 * NUM_BUFFERS;
  localparam int ADDR_W      = 7;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_RDWR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_DONE  = 2'b11
  } seq_state_e;

endpackage

// File: rtl/bdf_code_mem.sv
// Program store for the sequencer: one write port, one synchronous read port.
// Contents are never reset.
module bdf_code_mem #(
  parameter int DEPTH  = 128,
  parameter int WIDTH  = 24,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bdf_prog_sequencer.sv
// Steps through a stored program of per-buffer read/write requests, issuing
// each word only when all its buffers are ready. Optional stall counter: SEQ_STALL_CNT_EN.
module bdf_prog_sequencer #(
  parameter int NUM_BUFFERS = defines_pkg::NUM_BUFFERS,
  parameter int CODE_LENGTH = defines_pkg::CODE_LENGTH,
  parameter int CODE_WIDTH  = defines_pkg::CODE_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   prog_we,
  input  logic [6:0]             prog_addr,
  input  logic [CODE_WIDTH-1:0]  prog_wdata,
  input  logic [NUM_BUFFERS-1:0] buf_empty,
  input  logic [NUM_BUFFERS-1:0] buf_full,
  output logic [NUM_BUFFERS-1:0] buf_rd_en,
  output logic [NUM_BUFFERS-1:0] buf_wr_en,
  output logic [6:0]             pc,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            stall_cycles
);

  import defines_pkg::*;

  localparam logic [6:0] LAST_PC = 7'(CODE_LENGTH - 1);

  seq_state_e             state_q, state_d;
  logic [6:0]             pc_q, pc_d;
  logic [6:0]             rd_addr;
  logic [CODE_WIDTH-1:0]  instr;
  logic [NUM_BUFFERS-1:0] rd_req, wr_req;
  logic                   fire;
  logic                   mem_we;

  // Writes are only accepted while idle so a running program never changes.
  assign mem_we = prog_we & ~busy;

  bdf_code_mem #(
    .DEPTH  (CODE_LENGTH),
    .WIDTH  (CODE_WIDTH),
    .ADDR_W (7)
  ) u_code_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_wdata),
    .raddr (rd_addr),
    .rdata (instr)
  );

  always_comb begin
    rd_req = '0;
    wr_req = '0;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      case (op_e'(instr[2*i +: 2]))
        OP_READ:  rd_req[i] = 1'b1;
        OP_WRITE: wr_req[i] = 1'b1;
        OP_RDWR: begin
          rd_req[i] = 1'b1;
          wr_req[i] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign fire      = (state_q == ST_EXEC) && !(|(rd_req & buf_empty)) && !(|(wr_req & buf_full));
  assign buf_rd_en = fire ? rd_req : '0;
  assign buf_wr_en = fire ? wr_req : '0;

  // The read address runs one word ahead on a fire so consecutive fires
  // see the next instruction without a bubble; otherwise the current word is reread.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rd_addr = pc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH: begin
        rd_addr = '0;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (fire) begin
          if (pc_q == LAST_PC) begin
            state_d = ST_DONE;
          end else begin
            pc_d    = pc_q + 7'd1;
            rd_addr = pc_q + 7'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc   = pc_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

`ifdef SEQ_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_IDLE && start) begin
      stall_d = '0;
    end else if (state_q == ST_EXEC && !fire && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_bdf_prog_sequencer.sv
// Directed bench for bdf_prog_sequencer: a table of single-word vectors plus
// hand-written runs for full-length timing, stalls, mid-run reset and busy writes.
module tb_bdf_prog_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, prog_we;
  logic [6:0]  prog_addr;
  logic [23:0] prog_wdata;
  logic [11:0] buf_empty, buf_full;
  logic [11:0] buf_rd_en, buf_wr_en;
  logic [6:0]  pc;
  logic        busy, done;
  logic [15:0] stall_cycles;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  typedef struct packed {
    logic [23:0] word;
    logic [11:0] e;
    logic [11:0] f;
    logic [11:0] rd;
    logic [11:0] wr;
    logic        fire;
  } vec_t;

  vec_t vecs [11];

  bdf_prog_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_wdata   (prog_wdata),
    .buf_empty    (buf_empty),
    .buf_full     (buf_full),
    .buf_rd_en    (buf_rd_en),
    .buf_wr_en    (buf_wr_en),
    .pc           (pc),
    .busy         (busy),
    .done         (done),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic load(input logic [6:0] a, input logic [23:0] d);
    prog_we    = 1'b1;
    prog_addr  = a;
    prog_wdata = d;
    step();
    prog_we    = 1'b0;
  endtask

  task automatic load_all(input logic [23:0] d);
    for (int i = 0; i < 128; i++) load(7'(i), d);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    cyc   = 1;
  endtask

  task automatic run_to_done(output int dcyc);
    int guard = 0;
    while (!done && guard < 400) begin
      step();
      guard++;
    end
    dcyc = done ? cyc : -1;
  endtask

  task automatic step_until_pc(input int p);
    int guard = 0;
    while (int'(pc) != p && guard < 300) begin
      step();
      guard++;
    end
    chk("reach_pc", 32'(pc), 32'(p));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int dcyc, rd_cnt, first, last, dcount;
    logic [15:0] exp_stall;

    vecs[0]  = '{24'h000000, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 1'b1};
    vecs[1]  = '{24'h000001, 12'h000, 12'h000, 12'h001, 12'h000, 1'b1};
    vecs[2]  = '{24'h000008, 12'h000, 12'h002, 12'h000, 12'h000, 1'b0};
    vecs[3]  = '{24'h00C000, 12'h080, 12'h000, 12'h000, 12'h000, 1'b0};
    vecs[4]  = '{24'h00C000, 12'h000, 12'h000, 12'h080, 12'h080, 1'b1};
    vecs[5]  = '{24'h000080, 12'hFFF, 12'h000, 12'h000, 12'h008, 1'b1};
    vecs[6]  = '{24'hC00000, 12'h000, 12'h800, 12'h000, 12'h000, 1'b0};
    vecs[7]  = '{24'h000021, 12'h004, 12'h001, 12'h001, 12'h004, 1'b1};
    vecs[8]  = '{24'hFFFFFF, 12'h000, 12'h000, 12'hFFF, 12'hFFF, 1'b1};
    vecs[9]  = '{24'hAAAAAA, 12'hFFF, 12'h000, 12'h000, 12'hFFF, 1'b1};
    vecs[10] = '{24'h555555, 12'h800, 12'hFFF, 12'h000, 12'h000, 1'b0};

    reset = 1'b1; start = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_wdata = '0; buf_empty = '0; buf_full = '0;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_pc",    32'(pc), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_done",  32'(done), 32'h0);
    chk("rst_rd",    32'(buf_rd_en), 32'h0);
    chk("rst_wr",    32'(buf_wr_en), 32'h0);
    chk("rst_stall", 32'(stall_cycles), 32'h0);

    // Full-length run of reads on buffer 0.
    load_all(24'h000001);
    do_start();
    chk("a_fetch_busy", 32'(busy), 32'h1);
    chk("a_fetch_pc",   32'(pc), 32'h0);
    chk("a_fetch_rd",   32'(buf_rd_en), 32'h0);
    rd_cnt = 0; first = -1; last = -1;
    begin
      int guard = 0;
      while (!done && guard < 400) begin
        step();
        guard++;
        if (buf_rd_en[0]) begin
          rd_cnt++;
          if (first < 0) first = cyc;
          last = cyc;
        end
      end
    end
    chk("a_done_cycle", 32'(cyc), 32'd130);
    chk("a_done",       32'(done), 32'h1);
    chk("a_rd_count",   32'(rd_cnt), 32'd128);
    chk("a_rd_first",   32'(first), 32'd2);
    chk("a_rd_span",    32'(last - first + 1), 32'd128);
    step();
    chk("a_done_pulse", 32'(done), 32'h0);
    chk("a_idle_busy",  32'(busy), 32'h0);

    // Reset in the middle of a run, then rerun from word 0.
    do_start();
    step_until_pc(60);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("d_busy",  32'(busy), 32'h0);
    chk("d_pc",    32'(pc), 32'h0);
    chk("d_rd",    32'(buf_rd_en), 32'h0);
    chk("d_wr",    32'(buf_wr_en), 32'h0);
    chk("d_done",  32'(done), 32'h0);
    chk("d_stall", 32'(stall_cycles), 32'h0);
    do_start();
    chk("d_rerun_pc", 32'(pc), 32'h0);
    step();
    chk("d_rerun_rd", 32'(buf_rd_en), 32'h001);
    chk("d_rerun_pc0", 32'(pc), 32'h0);
    run_to_done(dcyc);
    chk("d_done_cycle", 32'(dcyc), 32'd130);
    step();

    // Program write and second start while busy are both ignored.
    do_start();
    step_until_pc(10);
    start = 1'b1;
    load(7'd0, 24'hFFFFFF);
    start = 1'b0;
    dcount = 0; dcyc = -1;
    while (cyc < 250) begin
      step();
      if (done) begin
        dcount++;
        if (dcyc < 0) dcyc = cyc;
      end
    end
    chk("e_done_count", 32'(dcount), 32'd1);
    chk("e_done_cycle", 32'(dcyc), 32'd130);
    do_start();
    step();
    chk("e_word0_rd", 32'(buf_rd_en), 32'h001);
    chk("e_word0_wr", 32'(buf_wr_en), 32'h000);
    run_to_done(dcyc);
    step();

    // Word 5 writes buffer 3 while buffer 3 stays full for four cycles.
    load_all(24'h000000);
    load(7'd5, 24'h000080);
    buf_full = 12'h008;
    do_start();
    step_until_pc(5);
    for (int i = 0; i < 4; i++) begin
      chk("b_hold_pc", 32'(pc), 32'h5);
      chk("b_hold_wr", 32'(buf_wr_en), 32'h0);
      chk("b_hold_rd", 32'(buf_rd_en), 32'h0);
      step();
    end
    buf_full = 12'h000;
    #1;
    chk("b_release_wr", 32'(buf_wr_en), 32'h008);
    chk("b_release_pc", 32'(pc), 32'h5);
    step();
    chk("b_next_pc", 32'(pc), 32'h6);
    chk("b_next_wr", 32'(buf_wr_en), 32'h0);
    run_to_done(dcyc);
    chk("b_done_cycle", 32'(dcyc), 32'd134);
`ifdef SEQ_STALL_CNT_EN
    exp_stall = 16'd4;
`else
    exp_stall = 16'd0;
`endif
    chk("b_stall", 32'(stall_cycles), 32'(exp_stall));
    step();

    // Table of single-word vectors at addresses 0..10.
    load_all(24'h000000);
    for (int k = 0; k < 11; k++) load(7'(k), vecs[k].word);
    do_start();
    step();
    for (int k = 0; k < 11; k++) begin
      buf_empty = vecs[k].e;
      buf_full  = vecs[k].f;
      #1;
      chk("t_rd", 32'(buf_rd_en), 32'(vecs[k].rd));
      chk("t_wr", 32'(buf_wr_en), 32'(vecs[k].wr));
      chk("t_pc", 32'(pc), 32'(k));
      step();
      if (!vecs[k].fire) begin
        chk("t_hold_pc", 32'(pc), 32'(k));
        buf_empty = '0;
        buf_full  = '0;
        step();
      end
      buf_empty = '0;
      buf_full  = '0;
    end
    chk("t_pc_after", 32'(pc), 32'd11);
    run_to_done(dcyc);
    chk("t_done_cycle", 32'(dcyc), 32'd134);
    chk("t_stall", 32'(stall_cycles), 32'(exp_stall));
    step();
    chk("t_idle", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bdf_prog_sequencer.md
BDF_PROG_SEQUENCER -- requirements
Module: bdf_prog_sequencer

Interface
REQ-001 SHALL have parameter NUM_BUFFERS, default 12: number of controlled buffers.
REQ-002 SHALL have parameter CODE_LENGTH, default 128: program depth, equal to ITERATION_BOUND.
REQ-003 SHALL have parameter CODE_WIDTH, default 24: program word width, 2*NUM_BUFFERS.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous reset, active-high.
REQ-006 SHALL have port start, input, 1: one-cycle pulse that begins a program run.
REQ-007 SHALL have port prog_we, input, 1: program memory write enable.
REQ-008 SHALL have port prog_addr, input, 7: program memory write address.
REQ-009 SHALL have port prog_wdata, input, CODE_WIDTH: program word to write.
REQ-010 SHALL have port buf_empty, input, NUM_BUFFERS: per-buffer empty flags.
REQ-011 SHALL have port buf_full, input, NUM_BUFFERS: per-buffer full flags.
REQ-012 SHALL have port buf_rd_en, output, NUM_BUFFERS: per-buffer pop strobes.
REQ-013 SHALL have port buf_wr_en, output, NUM_BUFFERS: per-buffer push strobes.
REQ-014 SHALL have port pc, output, 7: index of the current instruction.
REQ-015 SHALL have port busy, output, 1: high outside IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-017 SHALL have port stall_cycles, output, 16: stall count (see Configuration).

Function
REQ-018 SHALL decode buffer i from word bits [2i+1:2i]: 00 none, 01 read, 10 write, 11 read+write.
REQ-019 SHALL implement states IDLE, FETCH, EXEC, DONE.
REQ-020 SHALL go IDLE->FETCH on start and clear pc to 0; start outside IDLE SHALL be ignored.
REQ-021 SHALL use FETCH (one cycle) to read word 0 into the instruction register, then enter EXEC.
REQ-022 SHALL compute fire = EXEC AND no requested read has buf_empty AND no requested write has buf_full, from the same-cycle flags.
REQ-023 SHALL assert buf_rd_en and buf_wr_en combinationally only when fire is high, per the decode; otherwise all bits SHALL be 0.
REQ-024 SHALL, when fire is high and pc < CODE_LENGTH-1, increment pc and load word pc+1 so that back-to-back fires have no bubble.
REQ-025 SHALL, when fire is high and pc == CODE_LENGTH-1, go to DONE; DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-026 SHALL treat an all-zero word as always firing, i.e. a one-cycle no-op.
REQ-027 SHALL write prog_wdata into memory when prog_we is high and busy is low; prog_we while busy SHALL be dropped.
REQ-028 SHALL give one run a length of exactly 1 + CODE_LENGTH + stall cycles from start to the done pulse.

Reset
REQ-029 SHALL, on reset, force state IDLE, pc=0, busy=0, done=0, buf_rd_en=0, buf_wr_en=0 and stall_cycles=0, including mid-run.
REQ-030 SHALL NOT clear program memory contents on reset.

Configuration
REQ-031 SHALL, with SEQ_STALL_CNT_EN defined, increment stall_cycles (saturating at 0xFFFF) in each EXEC cycle with fire low, and clear it on start.
REQ-032 SHALL, without SEQ_STALL_CNT_EN, tie stall_cycles to 0 and instantiate no counter logic.

Structure
REQ-033 SHALL place the 2-bit opcode enum and the sequencer state enum in defines_pkg, alongside NUM_BUFFERS, CODE_LENGTH and CODE_WIDTH.
REQ-034 SHALL implement program storage as sub-module bdf_code_mem: CODE_LENGTH x CODE_WIDTH, synchronous read, one write port.

Verification
REQ-035 SHALL cover: load 128 words with buffer0=01, all flags ready, start -> buf_rd_en[0] high for 128 consecutive cycles, done on cycle 130 after start.
REQ-036 SHALL cover: word 5 = write on buffer3, buf_full[3]=1 for 4 cycles -> pc holds at 5, all enables 0, then buf_wr_en[3] pulses once; stall_cycles=4 with SEQ_STALL_CNT_EN.
REQ-037 SHALL cover: word with buffer7=11, buf_empty[7]=1 and buf_full[7]=0 -> no fire until empty clears, then rd_en[7] and wr_en[7] high in the same cycle.
REQ-038 SHALL cover: reset asserted at pc=60 -> next cycle IDLE, pc=0, enables 0; a following start reruns the same program from word 0.
REQ-039 SHALL cover: prog_we and a second start while busy -> memory unchanged and the run is not restarted; done pulses exactly once.
